dfc_sequencer: RTL

Upstream command/data sequencer for the DFC (data-frame compute) block. Buffers an 8-byte frame arriving from a host valid/ready byte stream and replays it into DFC as a load command plus 8-cycle data burst. Turns host read requests into DFC FIFO/LIFO read commands, honouring DFC's `busy` handshake so that no command is issued while DFC is working.

---
 rtl/dfc_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dfc_sequencer.sv
// dfc_sequencer: buffers an 8-byte host frame and replays it into DFC as a
// load command plus an 8-cycle data burst. Host read requests become DFC
// FIFO/LIFO read commands, and no command is issued while DFC is busy.
//
// Optional feature: define DFC_SEQ_AUTO_READ_EN to issue an automatic FIFO
// read (no rd_ack) once DFC goes idle after each load.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   s_data/s_valid/s_ready  host byte stream (valid/ready)
//   rd_req, rd_mode     host read request (level) and order (0 FIFO, 1 LIFO)
//   rd_ack              one-cycle pulse when the read command is issued
//   dfc_cmd, dfc_cmd_valid  DFC command (0 load, 1 FIFO rd, 2 LIFO rd) + strobe
//   dfc_datain          frame byte to DFC during the load burst
//   dfc_busy            DFC busy handshake
//   frame_loaded        DFC holds a valid frame
//   err                 sticky: dfc_busy did not rise within BUSY_TIMEOUT
module dfc_sequencer #(
  parameter int BUSY_TIMEOUT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       rd_req,
  input  logic       rd_mode,
  output logic       rd_ack,
  output logic [1:0] dfc_cmd,
  output logic       dfc_cmd_valid,
  output logic [7:0] dfc_datain,
  input  logic       dfc_busy,
  output logic       frame_loaded,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, CMD, STREAM, WAIT_HI, WAIT_LO} state_t;
  localparam int CW = $clog2(BUSY_TIMEOUT + 1) < 1 ? 1 : $clog2(BUSY_TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [7:0]    frame_q [8];
  logic [7:0]    frame_d [8];
  logic [3:0]    wp_q, wp_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d;
  logic          rd_ack_q, rd_ack_d;
  logic [1:0]    cmd_q, cmd_d;
  logic          cv_q, cv_d;
  logic [7:0]    din_q, din_d;
  logic          fl_q, fl_d;
  logic          err_q, err_d;
  logic          auto_q, auto_d;
  logic          s_fire;

  // s_ready_q is the registered output, so a transfer is judged against it
  assign s_fire = s_valid && s_ready_q;

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    wp_d      = wp_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    fl_d      = fl_q;
    err_d     = err_q;
    auto_d    = auto_q;
    cmd_d     = 2'd0;
    cv_d      = 1'b0;
    rd_ack_d  = 1'b0;
    din_d     = 8'd0;

    if (s_fire) begin
      frame_d[wp_q[2:0]] = s_data;
      wp_d = wp_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (!dfc_busy) begin
          // read wins over load so a pending host read is never starved
          if (rd_req && fl_q) begin
            cmd_d    = rd_mode ? 2'd2 : 2'd1;
            cv_d     = 1'b1;
            rd_ack_d = 1'b1;
            state_d  = CMD;
          end else if (wp_q == 4'd8) begin
            cv_d    = 1'b1;
            idx_d   = 3'd0;
            state_d = STREAM;
          end
        end
      end
      // strobe cycle of a read; counts as the first busy-wait cycle
      CMD: begin
        cnt_d = CW'(1);
        if (dfc_busy) state_d = WAIT_LO;
        else if (BUSY_TIMEOUT <= 1) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else state_d = WAIT_HI;
      end
      // dfc_busy is ignored here: DFC is loading
      STREAM: begin
        din_d = frame_q[idx_q];
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          wp_d    = 4'd0;
          fl_d    = 1'b1;
          state_d = WAIT_LO;
`ifdef DFC_SEQ_AUTO_READ_EN
          auto_d  = 1'b1;
`endif
        end
      end
      WAIT_HI: begin
        if (dfc_busy) state_d = WAIT_LO;
        else begin
          cnt_d = cnt_q + CW'(1);
          if (int'(cnt_q) + 1 >= BUSY_TIMEOUT) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_LO: begin
        if (!dfc_busy) begin
          state_d = IDLE;
`ifdef DFC_SEQ_AUTO_READ_EN
          if (auto_q) begin
            cmd_d   = 2'd1;
            cv_d    = 1'b1;
            auto_d  = 1'b0;
            state_d = CMD;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // registered ready reflects the state/pointer we are moving into
    s_ready_d = (state_d == IDLE) && (wp_d < 4'd8);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      for (int i = 0; i < 8; i++) frame_q[i] <= 8'd0;
      wp_q      <= 4'd0;
      idx_q     <= 3'd0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      cmd_q     <= 2'd0;
      cv_q      <= 1'b0;
      din_q     <= 8'd0;
      fl_q      <= 1'b0;
      err_q     <= 1'b0;
      auto_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      wp_q      <= wp_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      rd_ack_q  <= rd_ack_d;
      cmd_q     <= cmd_d;
      cv_q      <= cv_d;
      din_q     <= din_d;
      fl_q      <= fl_d;
      err_q     <= err_d;
      auto_q    <= auto_d;
    end
  end

  assign s_ready       = s_ready_q;
  assign rd_ack        = rd_ack_q;
  assign dfc_cmd       = cmd_q;
  assign dfc_cmd_valid = cv_q;
  assign dfc_datain    = din_q;
  assign frame_loaded  = fl_q;
  assign err           = err_q;
endmodule
